// File: rtl/ecall_io_sequencer.sv
// Ecall I/O sequencer: stalls the datapath on ecall and runs print/read/exit services.
// Optional print auto-confirm timeout enabled by defining ECALL_TIMEOUT_EN.
module ecall_io_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned TIMEOUT_CYCLES  = 50000000,
    parameter int unsigned SVC_PRINT       = 1,
    parameter int unsigned SVC_READ        = 5,
    parameter int unsigned SVC_EXIT        = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ecall_req,
    input  logic [31:0] svc_code,
    input  logic [31:0] arg_data,
    input  logic [7:0]  switch_in,
    input  logic        confirm_btn,
    output logic        stall,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic [31:0] tube_data,
    output logic        wait_led,
    output logic        halted
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitIn,
        StWaitOut,
        StDone,
        StHalt
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     sync_q;
    logic           db_level_q;
    logic [DbW-1:0] db_cnt_q;
    logic           confirm_q;
    logic           from_read_q;
    logic [31:0]    tube_q;
    logic [31:0]    wb_data_q;
    logic           timeout;

    // Synchroniser plus debounce; confirm_q pulses once per accepted 0->1 level change.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= 2'b00;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            confirm_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], confirm_btn};
            confirm_q <= 1'b0;
            if (sync_q[1] == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DbLast) begin
                db_level_q <= sync_q[1];
                db_cnt_q   <= '0;
                confirm_q  <= sync_q[1];
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

`ifdef ECALL_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    // Held at zero outside WAIT_OUT, so it always starts from zero on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q != StWaitOut) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end

    assign timeout = (state_q == StWaitOut) && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        wait_led = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ecall_req) begin
                    stall = 1'b1;
                    if (svc_code == SVC_PRINT) begin
                        state_d = StWaitOut;
                    end else if (svc_code == SVC_READ) begin
                        state_d = StWaitIn;
                    end else if (svc_code == SVC_EXIT) begin
                        state_d = StHalt;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWaitIn: begin
                stall    = 1'b1;
                wait_led = 1'b1;
                if (confirm_q) begin
                    state_d = StDone;
                end
            end
            StWaitOut: begin
                stall    = 1'b1;
                wait_led = 1'b1;
                if (confirm_q || timeout) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StHalt: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            from_read_q <= 1'b0;
            tube_q      <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            from_read_q <= (state_q == StWaitIn) && confirm_q;
            if ((state_q == StIdle) && ecall_req && (svc_code == SVC_PRINT)) begin
                tube_q <= arg_data;
            end
            if ((state_q == StWaitIn) && confirm_q) begin
                wb_data_q <= {24'b0, switch_in};
            end
        end
    end

    assign wb_en     = (state_q == StDone) && from_read_q;
    assign wb_data   = wb_data_q;
    assign tube_data = tube_q;

endmodule
